div_int16_by_int8: RTL

Sequential signed integer divider: 16-bit two's-complement dividend ÷ 8-bit two's-complement divisor, producing a truncated quotient and a remainder. It is the inverse of the INT8 Booth multiplier in the MAC datapath. The tensor-core post-processing path uses it to scale and requantize accumulated INT16 products back by an INT8 factor. The datapath is a radix-2 restoring array, one quotient bit per cycle, with valid/ready handshakes on input and output.

---
 rtl/div_int16_by_int8.sv | 134 +++++++++++++
 1 files changed

// File: rtl/div_int16_by_int8.sv
// Sequential signed divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor,
// radix-2 restoring, one quotient bit per cycle, valid/ready on both sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// CALC  | one restoring iteration per cycle on magnitudes, DIVIDEND_W cycles
// FIX   | apply signs and special-case overrides, load output registers
// DONE  | out_valid high, outputs held until out_ready
module div_int16_by_int8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DIVIDEND_W-1:0] quotient_o,
  output logic [DIVISOR_W-1:0]  remainder_o,
  output logic                  div_by_zero_o,
  output logic                  overflow_o
);
  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                state_q;
  logic                  in_ready_q, out_valid_q;
  logic                  sgn_dvd_q, sgn_dvs_q, dbz_q, ovf_q;
  logic [DIVIDEND_W-1:0] dvd_q;
  logic [DIVISOR_W:0]    dvs_q;
  // Partial remainder is always below |divisor| <= 2^(DIVISOR_W-1), so DIVISOR_W bits hold it.
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  dvd_lo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  dbz_out_q, ovf_out_q;

  logic [DIVIDEND_W-1:0] dvd_abs_d;
  logic [DIVISOR_W:0]    dvs_ext_d, dvs_abs_d;
  logic [DIVISOR_W:0]    rem_sh_d;
  logic                  trial_ge_d, dbz_d, ovf_d;

  always_comb begin
    dvd_abs_d  = dividend_i[DIVIDEND_W-1] ? -dividend_i : dividend_i;
    dvs_ext_d  = {divisor_i[DIVISOR_W-1], divisor_i};
    dvs_abs_d  = dvs_ext_d[DIVISOR_W] ? -dvs_ext_d : dvs_ext_d;
    dbz_d      = (divisor_i == '0);
    ovf_d      = (dividend_i == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (divisor_i == '1);
    rem_sh_d   = {rem_q, dvd_q[DIVIDEND_W-1]};
    trial_ge_d = (rem_sh_d >= dvs_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sgn_dvd_q   <= 1'b0;
      sgn_dvs_q   <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      dvd_lo_q    <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_out_q   <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            sgn_dvd_q  <= dividend_i[DIVIDEND_W-1];
            sgn_dvs_q  <= divisor_i[DIVISOR_W-1];
            dvd_q      <= dvd_abs_d;
            dvs_q      <= dvs_abs_d;
            rem_q      <= '0;
            dvd_lo_q   <= dividend_i[DIVISOR_W-1:0];
            cnt_q      <= '0;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          rem_q <= trial_ge_d ? DIVISOR_W'(rem_sh_d - dvs_q) : DIVISOR_W'(rem_sh_d);
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], trial_ge_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          if (dbz_q) begin
            quotient_q  <= '1;
            remainder_q <= dvd_lo_q;
          end else if (ovf_q) begin
            quotient_q  <= {1'b1, {(DIVIDEND_W-1){1'b0}}};
            remainder_q <= '0;
          end else begin
            quotient_q  <= (sgn_dvd_q ^ sgn_dvs_q) ? -dvd_q : dvd_q;
            remainder_q <= sgn_dvd_q ? -rem_q : rem_q;
          end
          dbz_out_q   <= dbz_q;
          ovf_out_q   <= ovf_q;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_out_q;
  assign overflow_o    = ovf_out_q;
endmodule
